// File: rtl/exception_unit_pkg.sv
// Shared definitions for the exception unit: FSM states, cause codes,
// status bit positions and the saturating counter helper.
package exception_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TAKE = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_IRQ   = 2'd0;
  localparam logic [1:0] CAUSE_OVF   = 2'd1;
  localparam logic [1:0] CAUSE_UNDEF = 2'd2;
  localparam logic [1:0] CAUSE_TRAP  = 2'd3;

  localparam int unsigned ST_CUR  = 0;
  localparam int unsigned ST_PREV = 1;
  localparam int unsigned ST_OLD  = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/exception_unit_status_stack.sv
// Three-deep interrupt-enable stack {old, prev, cur}.
// Push beats pop, pop beats a software write.
module exception_unit_status_stack
  import exception_unit_pkg::*;
#(
  parameter logic RESET_IE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       we,
  input  logic [2:0] wdata,
  output logic [2:0] status
);

  logic [2:0] status_d;
  logic [2:0] status_q;

  // Next stack value: push clears cur, pop restores from the deeper entries.
  always_comb begin
    status_d = status_q;
    if (push) begin
      status_d = {status_q[ST_PREV], status_q[ST_CUR], 1'b0};
    end else if (pop) begin
      status_d = {status_q[ST_OLD], status_q[ST_OLD], status_q[ST_PREV]};
    end else if (we) begin
      status_d = wdata;
    end else begin
      status_d = status_q;
    end
  end

  // Stack register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q <= {2'b00, RESET_IE};
    end else begin
      status_q <= status_d;
    end
  end

  assign status = status_q;

endmodule

// File: rtl/exception_unit.sv
// Exception selection, EPC/cause capture and fetch redirect with a
// valid/ready handshake; also executes rfe as a stack pop plus return redirect.
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_0080,
  parameter logic        RESET_IE    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic        no_define,
  input  logic        trap_sign,
  input  logic        ovf,
  input  logic        rfe,
  input  logic        ext_irq,
  input  logic        status_we,
  input  logic [2:0]  status_wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        flush,
  output logic        stall,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic [2:0]  status,
  output logic [15:0] exc_count
);

  state_e      state_d, state_q;
  logic        redirect_valid_d, redirect_valid_q;
  logic [31:0] redirect_pc_d, redirect_pc_q;
  logic        flush_d, flush_q;
  logic [31:0] epc_d, epc_q;
  logic [1:0]  cause_d, cause_q;
  logic [15:0] exc_count_d, exc_count_q;
  logic        push_s, pop_s, we_s;
  logic        sync_exc_s;

  assign sync_exc_s = instr_valid && (no_define || ovf || trap_sign);

  // Next-state and register updates; inputs only matter while in RUN.
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    epc_d            = epc_q;
    cause_d          = cause_q;
    exc_count_d      = exc_count_q;
    push_s           = 1'b0;
    pop_s            = 1'b0;
    we_s             = 1'b0;
    case (state_q)
      ST_RUN: begin
        redirect_valid_d = 1'b0;
        if (sync_exc_s) begin
          push_s           = 1'b1;
          state_d          = ST_TAKE;
          redirect_valid_d = 1'b1;
          flush_d          = 1'b1;
          redirect_pc_d    = VECTOR_ADDR;
          epc_d            = pc + 32'd4;
          exc_count_d      = sat_inc16(exc_count_q);
          if (no_define) begin
            cause_d = CAUSE_UNDEF;
          end else if (ovf) begin
            cause_d = CAUSE_OVF;
          end else begin
            cause_d = CAUSE_TRAP;
          end
        end else if (instr_valid && rfe) begin
          // A coincident irq is deferred until the popped status is visible.
          pop_s            = 1'b1;
          state_d          = ST_TAKE;
          redirect_valid_d = 1'b1;
          flush_d          = 1'b1;
          redirect_pc_d    = epc_q;
        end else if (ext_irq && status[ST_CUR]) begin
          push_s           = 1'b1;
          state_d          = ST_TAKE;
          redirect_valid_d = 1'b1;
          flush_d          = 1'b1;
          redirect_pc_d    = VECTOR_ADDR;
          cause_d          = CAUSE_IRQ;
          exc_count_d      = sat_inc16(exc_count_q);
          if (instr_valid) begin
            epc_d = pc;
          end else begin
            epc_d = epc_q;
          end
        end else begin
          we_s = status_we;
        end
      end
      ST_TAKE, ST_WAIT: begin
        if (redirect_ready) begin
          state_d          = ST_RUN;
          redirect_valid_d = 1'b0;
        end else begin
          state_d          = ST_WAIT;
          redirect_valid_d = 1'b1;
        end
      end
      default: begin
        state_d          = ST_RUN;
        redirect_valid_d = 1'b0;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0000_0000;
      flush_q          <= 1'b0;
      epc_q            <= 32'h0000_0000;
      cause_q          <= 2'd0;
      exc_count_q      <= 16'd0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      epc_q            <= epc_d;
      cause_q          <= cause_d;
      exc_count_q      <= exc_count_d;
    end
  end

  exception_unit_status_stack #(
    .RESET_IE (RESET_IE)
  ) u_status_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_s),
    .pop    (pop_s),
    .we     (we_s),
    .wdata  (status_wdata),
    .status (status)
  );

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign stall          = (state_q != ST_RUN);
  assign epc            = epc_q;
  assign cause          = cause_q;
  assign exc_count      = exc_count_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: hand-computed expectations checked
// with immediate assertions one sample after each rising edge.
module tb_exception_unit;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] pc;
  logic        no_define;
  logic        trap_sign;
  logic        ovf;
  logic        rfe;
  logic        ext_irq;
  logic        status_we;
  logic [2:0]  status_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        flush;
  logic        stall;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic [2:0]  status;
  logic [15:0] exc_count;

  int total;
  int passed;
  int fails;

  exception_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .no_define      (no_define),
    .trap_sign      (trap_sign),
    .ovf            (ovf),
    .rfe            (rfe),
    .ext_irq        (ext_irq),
    .status_we      (status_we),
    .status_wdata   (status_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush          (flush),
    .stall          (stall),
    .epc            (epc),
    .cause          (cause),
    .status         (status),
    .exc_count      (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rv"},    32'(redirect_valid), 32'd0);
    chk({tag, "_rpc"},   redirect_pc,         32'h0000_0000);
    chk({tag, "_flush"}, 32'(flush),          32'd0);
    chk({tag, "_epc"},   epc,                 32'h0000_0000);
    chk({tag, "_cause"}, 32'(cause),          32'd0);
    chk({tag, "_st"},    32'(status),         32'd0);
    chk({tag, "_cnt"},   32'(exc_count),      32'd0);
    chk({tag, "_stall"}, 32'(stall),          32'd0);
  endtask

  initial begin
    total = 0; passed = 0; fails = 0;
    rst_n = 1'b0; instr_valid = 1'b0; pc = 32'h0; no_define = 1'b0;
    trap_sign = 1'b0; ovf = 1'b0; rfe = 1'b0; ext_irq = 1'b0;
    status_we = 1'b0; status_wdata = 3'b000; redirect_ready = 1'b0;
    step(); step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // 1: undefined instruction
    instr_valid = 1'b1; pc = 32'h0000_0100; no_define = 1'b1;
    step();
    instr_valid = 1'b0; no_define = 1'b0;
    chk("t1_rv",    32'(redirect_valid), 32'd1);
    chk("t1_rpc",   redirect_pc,         32'h0000_0080);
    chk("t1_flush", 32'(flush),          32'd1);
    chk("t1_epc",   epc,                 32'h0000_0104);
    chk("t1_cause", 32'(cause),          32'd2);
    chk("t1_cnt",   32'(exc_count),      32'd1);
    chk("t1_stall", 32'(stall),          32'd1);
    redirect_ready = 1'b1;
    step();
    chk("t1_ret_rv",    32'(redirect_valid), 32'd0);
    chk("t1_ret_stall", 32'(stall),          32'd0);
    chk("t1_ret_flush", 32'(flush),          32'd0);
    redirect_ready = 1'b0;

    // 2: software status write then irq with an instruction present
    status_we = 1'b1; status_wdata = 3'b001;
    step();
    status_we = 1'b0;
    chk("t2_stw", 32'(status), 32'b001);
    ext_irq = 1'b1; instr_valid = 1'b1; pc = 32'h0000_0200;
    step();
    ext_irq = 1'b0; instr_valid = 1'b0;
    chk("t2_cause", 32'(cause),          32'd0);
    chk("t2_epc",   epc,                 32'h0000_0200);
    chk("t2_st",    32'(status),         32'b010);
    chk("t2_rv",    32'(redirect_valid), 32'd1);
    chk("t2_cnt",   32'(exc_count),      32'd2);

    // 3: ready held low for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_rv",    32'(redirect_valid), 32'd1);
      chk("t3_rpc",   redirect_pc,         32'h0000_0080);
      chk("t3_flush", 32'(flush),          32'd0);
      chk("t3_stall", 32'(stall),          32'd1);
    end
    redirect_ready = 1'b1;
    step();
    chk("t3_ret_stall", 32'(stall),          32'd0);
    chk("t3_ret_rv",    32'(redirect_valid), 32'd0);
    redirect_ready = 1'b0;

    // 2b: irq masked while status[0]=0
    ext_irq = 1'b1;
    step();
    chk("t2b_rv",  32'(redirect_valid), 32'd0);
    chk("t2b_stl", 32'(stall),          32'd0);
    chk("t2b_cnt", 32'(exc_count),      32'd2);

    // 4b: rfe with irq pending, status 010 -> 001
    instr_valid = 1'b1; rfe = 1'b1;
    step();
    instr_valid = 1'b0; rfe = 1'b0; redirect_ready = 1'b1;
    chk("t4_rfe_rv",  32'(redirect_valid), 32'd1);
    chk("t4_rfe_rpc", redirect_pc,         32'h0000_0200);
    chk("t4_rfe_st",  32'(status),         32'b001);
    chk("t4_rfe_cnt", 32'(exc_count),      32'd2);
    chk("t4_rfe_fl",  32'(flush),          32'd1);
    step();
    chk("t4_run_stall", 32'(stall),          32'd0);
    chk("t4_run_rv",    32'(redirect_valid), 32'd0);
    step();
    ext_irq = 1'b0;
    chk("t4_irq_rv",    32'(redirect_valid), 32'd1);
    chk("t4_irq_rpc",   redirect_pc,         32'h0000_0080);
    chk("t4_irq_cause", 32'(cause),          32'd0);
    chk("t4_irq_epc",   epc,                 32'h0000_0200);
    chk("t4_irq_st",    32'(status),         32'b010);
    chk("t4_irq_cnt",   32'(exc_count),      32'd3);
    step();

    // 4a: overflow outranks trap
    instr_valid = 1'b1; pc = 32'h0000_0300; ovf = 1'b1; trap_sign = 1'b1;
    step();
    instr_valid = 1'b0; ovf = 1'b0; trap_sign = 1'b0;
    chk("t4_ovf_cause", 32'(cause),     32'd1);
    chk("t4_ovf_epc",   epc,            32'h0000_0304);
    chk("t4_ovf_st",    32'(status),    32'b100);
    chk("t4_ovf_cnt",   32'(exc_count), 32'd4);
    step();

    // 6b: status write coincident with an exception is dropped
    instr_valid = 1'b1; pc = 32'h0000_0400; no_define = 1'b1;
    status_we = 1'b1; status_wdata = 3'b111;
    step();
    instr_valid = 1'b0; no_define = 1'b0; status_we = 1'b0;
    chk("t6_we_st",    32'(status),    32'b000);
    chk("t6_we_cause", 32'(cause),     32'd2);
    chk("t6_we_cnt",   32'(exc_count), 32'd5);
    step();

    // 5: counter saturation and pc+4 wrap
    force dut.exc_count_d = 16'hFFFE;
    step();
    release dut.exc_count_d;
    chk("t5_preload", 32'(exc_count), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1; trap_sign = 1'b1;
      pc = (i == 2) ? 32'hFFFF_FFFC : 32'h0000_0600;
      step();
      instr_valid = 1'b0; trap_sign = 1'b0;
      chk("t5_cnt",   32'(exc_count), 32'h0000_FFFF);
      chk("t5_cause", 32'(cause),     32'd3);
      step();
    end
    chk("t5_wrap_epc", epc, 32'h0000_0000);

    // 6a: reset asserted while waiting for ready
    redirect_ready = 1'b0;
    instr_valid = 1'b1; pc = 32'h0000_0500; no_define = 1'b1;
    step();
    instr_valid = 1'b0; no_define = 1'b0;
    step();
    chk("t6_wait_rv",    32'(redirect_valid), 32'd1);
    chk("t6_wait_flush", 32'(flush),          32'd0);
    chk("t6_wait_stall", 32'(stall),          32'd1);
    rst_n = 1'b0;
    step();
    chk_reset_vals("t6_rst");
    rst_n = 1'b1;
    step();
    chk("t6_after_rv",    32'(redirect_valid), 32'd0);
    chk("t6_after_stall", 32'(stall),          32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
